// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcodes, FSM states,
// latched request payload and opcode legality.
package alu_arbiter_pkg;

  localparam int unsigned ALU_W = 32;
  localparam int unsigned OP_W  = 3;

  localparam logic [OP_W-1:0] OP_AND = 3'b000;
  localparam logic [OP_W-1:0] OP_OR  = 3'b001;
  localparam logic [OP_W-1:0] OP_ADD = 3'b010;
  localparam logic [OP_W-1:0] OP_SUB = 3'b110;
  localparam logic [OP_W-1:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [OP_W-1:0]  op;
    logic             id;
  } req_t;

  function automatic logic op_legal(input logic [OP_W-1:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_arbiter_yalu.sv
// yAlu: 32-bit combinational ALU; op[2] selects subtract, op[1:0] picks
// AND/OR/ADD/SLT. ex flags a zero result.
module yAlu
  import alu_arbiter_pkg::*;
(
  output logic [ALU_W-1:0] z,
  output logic             ex,
  input  logic [ALU_W-1:0] a,
  input  logic [ALU_W-1:0] b,
  input  logic [OP_W-1:0]  op
);

  logic [ALU_W-1:0] b_eff;
  logic [ALU_W-1:0] sum;
  logic             slt_c;

  always_comb begin
    b_eff = op[2] ? ~b : b;
    sum   = a + b_eff + ALU_W'(op[2]);
    // Differing signs decide directly; equal signs cannot overflow a - b.
    slt_c = (a[ALU_W-1] ^ b[ALU_W-1]) ? a[ALU_W-1] : sum[ALU_W-1];
    z     = '0;
    case (op[1:0])
      2'b00:   z = a & b;
      2'b01:   z = a | b;
      2'b10:   z = sum;
      default: z = ALU_W'(slt_c);
    endcase
    ex = (z == '0);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one yAlu between two requesters, one
// transaction in flight; results held in RESP until the consumer takes them.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_z,
  output logic             rsp_zero,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic             last_q, last_d;
  req_t             req_q, req_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_z_q, rsp_z_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             grant0_c, grant1_c, accept_c;
  logic [ALU_W-1:0] alu_z;
  logic             alu_ex;

  yAlu u_alu (
    .z  (alu_z),
    .ex (alu_ex),
    .a  (req_q.a),
    .b  (req_q.b),
    .op (req_q.op)
  );

  // last_q holds the id granted most recently; on a tie the other one wins.
  always_comb begin
    grant1_c   = req1_valid && (!req0_valid || !last_q);
    grant0_c   = req0_valid && !grant1_c;
    req0_ready = rst_n && (state_q == ST_IDLE) && grant0_c;
    req1_ready = rst_n && (state_q == ST_IDLE) && grant1_c;
    accept_c   = req0_ready || req1_ready;
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_z_d     = rsp_z_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          if (grant1_c) begin
            req_d.a  = ALU_W'(req1_a);
            req_d.b  = ALU_W'(req1_b);
            req_d.op = req1_op;
          end else begin
            req_d.a  = ALU_W'(req0_a);
            req_d.b  = ALU_W'(req0_b);
            req_d.op = req0_op;
          end
          req_d.id = grant1_c;
          last_d   = grant1_c;
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        rsp_id_d = req_q.id;
        if (op_legal(req_q.op)) begin
          rsp_z_d    = WIDTH'(alu_z);
          rsp_zero_d = alu_ex;
          rsp_err_d  = 1'b0;
        end else begin
          rsp_z_d    = '0;
          rsp_zero_d = 1'b0;
          rsp_err_d  = 1'b1;
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        // rsp_valid rises one cycle into RESP; the handshake needs it high.
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_z_q     <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_z_q     <= rsp_z_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_err   = rsp_err_q;

endmodule
